// File: rtl/maxpool2x2_layer2.sv
// 2x2 stride-2 signed max-pooling stage for layer_2's 64-channel stream.
// Horizontal pair max goes to a half-width line buffer, then a vertical max on odd rows.
module maxpool2x2_layer2 #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 64,
    parameter int IMG_W      = 12,
    parameter int IMG_H      = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic                           valid_out_pool,
    output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
    output logic                           frame_done
);

    localparam int W   = CHANNELS * DATA_WIDTH;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LBD = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_PAIR_LAST = CW'((IMG_W / 2) * 2 - 1);
    localparam logic [RW-1:0] ROW_PAIR_LAST = RW'((IMG_H / 2) * 2 - 1);

    function automatic logic [W-1:0] vmax(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if ($signed(a[c*DATA_WIDTH +: DATA_WIDTH]) >
                $signed(b[c*DATA_WIDTH +: DATA_WIDTH]))
                r[c*DATA_WIDTH +: DATA_WIDTH] = a[c*DATA_WIDTH +: DATA_WIDTH];
            else
                r[c*DATA_WIDTH +: DATA_WIDTH] = b[c*DATA_WIDTH +: DATA_WIDTH];
        end
        return r;
    endfunction

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [W-1:0]   h_q, h_d;
    logic [W-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;

    // Line buffer is never reset: every odd-row read follows an even-row write.
    logic [W-1:0]   lb_q [LBD];
    logic           lb_we;
    logic [LBW-1:0] lb_idx;
    logic [W-1:0]   hm;

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        h_d     = h_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        lb_we   = 1'b0;
        lb_idx  = LBW'(col_q >> 1);
        hm      = vmax(h_q, data_in);

        if (valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                h_d = data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                data_d  = vmax(lb_q[lb_idx], hm);
                valid_d = 1'b1;
                done_d  = (col_q == COL_PAIR_LAST) &&
                          (row_q == ROW_PAIR_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            h_q     <= h_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && lb_we)
            lb_q[lb_idx] <= hm;
    end

    assign valid_out_pool = valid_q;
    assign data_out       = data_q;
    assign frame_done     = done_q;

endmodule

// File: tb/tb_maxpool2x2_layer2.sv
// Directed bench for maxpool2x2_layer2 on a 4x4 map, 64 x 32-bit channels.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_maxpool2x2_layer2;

    localparam int DW = 32;
    localparam int CH = 64;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int W  = DW * CH;

    logic         clk;
    logic         rst_n;
    logic         valid_in;
    logic [W-1:0] data_in;
    logic         valid_out_pool;
    logic [W-1:0] data_out;
    logic         frame_done;

    int total = 0;
    int bad   = 0;

    maxpool2x2_layer2 #(
        .DATA_WIDTH(DW),
        .CHANNELS  (CH),
        .IMG_W     (IW),
        .IMG_H     (IH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .valid_out_pool(valid_out_pool),
        .data_out      (data_out),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = 32'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_px();
        logic [W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = $urandom;
        return r;
    endfunction

    // Present one pixel, let it be accepted, return on the next falling edge.
    task automatic drive(input logic [W-1:0] px);
        valid_in = 1'b1;
        data_in  = px;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            data_in  = rand_px();
            @(posedge clk);
            @(negedge clk);
            total++;
            if (valid_out_pool !== 1'b0) begin
                bad++;
                $display("FAIL rst_valid cyc=%0d got=%b exp=0", i, valid_out_pool);
            end
            total++;
            if (frame_done !== 1'b0) begin
                bad++;
                $display("FAIL rst_done cyc=%0d got=%b exp=0", i, frame_done);
            end
            total++;
            if (data_out !== '0) begin
                bad++;
                $display("FAIL rst_data cyc=%0d got=%h exp=0", i, data_out[31:0]);
            end
        end
        rst_n    = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (valid_out_pool !== 1'b0) begin
                bad++;
                $display("FAIL rst_idle cyc=%0d got=%b exp=0", i, valid_out_pool);
            end
        end
    endtask

    task automatic test_basic();
        int exp_v [4] = '{5, 7, 13, 15};
        int k = 0;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                drive(fill(r * 4 + c));
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    total++;
                    if (valid_out_pool !== 1'b1) begin
                        bad++;
                        $display("FAIL basic_valid r=%0d c=%0d got=%b exp=1", r, c, valid_out_pool);
                    end
                    total++;
                    if (data_out !== fill(exp_v[k])) begin
                        bad++;
                        $display("FAIL basic_data k=%0d got=%0d exp=%0d", k,
                                 $signed(data_out[31:0]), exp_v[k]);
                    end
                    total++;
                    if (frame_done !== (k == 3)) begin
                        bad++;
                        $display("FAIL basic_done k=%0d got=%b exp=%b", k, frame_done, k == 3);
                    end
                    k++;
                end else begin
                    total++;
                    if (valid_out_pool !== 1'b0 || frame_done !== 1'b0) begin
                        bad++;
                        $display("FAIL basic_quiet r=%0d c=%0d got=%b%b exp=00", r, c,
                                 valid_out_pool, frame_done);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (valid_out_pool !== 1'b0 || data_out !== fill(15)) begin
            bad++;
            $display("FAIL basic_hold got=%b/%0d exp=0/15", valid_out_pool,
                     $signed(data_out[31:0]));
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] win [4];
        logic [W-1:0] exp_px;
        logic [W-1:0] px;
        int ch0_v [4] = '{-5, -1, -7, -3};
        logic [31:0] ch63_v [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h1};
        for (int k = 0; k < 4; k++) begin
            win[k] = '0;
            win[k][31:0] = 32'(ch0_v[k]);
            win[k][63*DW +: DW] = ch63_v[k];
            for (int c = 1; c < 63; c++)
                win[k][c*DW +: DW] = (k == c % 4) ? 32'(c + 1000) : 32'(-c);
        end
        exp_px = '0;
        exp_px[31:0] = 32'hFFFF_FFFF;
        exp_px[63*DW +: DW] = 32'h7FFF_FFFF;
        for (int c = 1; c < 63; c++) exp_px[c*DW +: DW] = 32'(c + 1000);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                px = (r < 2 && c < 2) ? win[r * 2 + c] : '0;
                drive(px);
                if (r == 1 && c == 1) begin
                    total++;
                    if (valid_out_pool !== 1'b1) begin
                        bad++;
                        $display("FAIL signed_valid got=%b exp=1", valid_out_pool);
                    end
                    total++;
                    if (data_out[31:0] !== 32'hFFFF_FFFF) begin
                        bad++;
                        $display("FAIL signed_ch0 got=%h exp=ffffffff", data_out[31:0]);
                    end
                    total++;
                    if (data_out[63*DW +: DW] !== 32'h7FFF_FFFF) begin
                        bad++;
                        $display("FAIL signed_ch63 got=%h exp=7fffffff", data_out[63*DW +: DW]);
                    end
                    for (int ch = 1; ch < 63; ch++) begin
                        total++;
                        if (data_out[ch*DW +: DW] !== exp_px[ch*DW +: DW]) begin
                            bad++;
                            $display("FAIL signed_ch%0d got=%0d exp=%0d", ch,
                                     $signed(data_out[ch*DW +: DW]), ch + 1000);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_gapped();
        int exp_v [4] = '{5, 7, 13, 15};
        int k = 0;
        int gap;
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                gap = $urandom_range(0, 5);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    total++;
                    if (valid_out_pool !== 1'b0) begin
                        bad++;
                        $display("FAIL gap_quiet r=%0d c=%0d got=%b exp=0", r, c, valid_out_pool);
                    end
                end
                drive(fill(r * 4 + c));
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    total++;
                    if (valid_out_pool !== 1'b1 || data_out !== fill(exp_v[k])) begin
                        bad++;
                        $display("FAIL gap_out k=%0d got=%b/%0d exp=1/%0d", k, valid_out_pool,
                                 $signed(data_out[31:0]), exp_v[k]);
                    end
                    total++;
                    if (frame_done !== (k == 3)) begin
                        bad++;
                        $display("FAIL gap_done k=%0d got=%b exp=%b", k, frame_done, k == 3);
                    end
                    k++;
                end else begin
                    total++;
                    if (valid_out_pool !== 1'b0) begin
                        bad++;
                        $display("FAIL gap_early r=%0d c=%0d got=%b exp=0", r, c, valid_out_pool);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_v [8] = '{5, 7, 13, 15, 105, 107, 113, 115};
        int k = 0;
        int dones = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < IH; r++) begin
                for (int c = 0; c < IW; c++) begin
                    valid_in = 1'b1;
                    data_in  = fill(r * 4 + c + 100 * f);
                    @(posedge clk);
                    @(negedge clk);
                    if (valid_out_pool === 1'b1) begin
                        total++;
                        if (k >= 8 || data_out !== fill(exp_v[k % 8])) begin
                            bad++;
                            $display("FAIL b2b_data k=%0d got=%0d exp=%0d", k,
                                     $signed(data_out[31:0]), exp_v[k % 8]);
                        end
                        k++;
                    end
                    if (frame_done === 1'b1) dones++;
                end
            end
        end
        valid_in = 1'b0;
        total++;
        if (k !== 8) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=8", k);
        end
        total++;
        if (dones !== 2) begin
            bad++;
            $display("FAIL b2b_done got=%0d exp=2", dones);
        end
    endtask

    task automatic test_mid_reset();
        int exp_v [4] = '{205, 207, 213, 215};
        int k = 0;
        for (int i = 0; i < 6; i++) drive(fill(900 + i));
        rst_n    = 1'b0;
        valid_in = 1'b1;
        data_in  = fill(999);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        total++;
        if (valid_out_pool !== 1'b0 || data_out !== '0) begin
            bad++;
            $display("FAIL mrst_clear got=%b/%0d exp=0/0", valid_out_pool,
                     $signed(data_out[31:0]));
        end
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                drive(fill(200 + r * 4 + c));
                if (valid_out_pool === 1'b1) begin
                    total++;
                    if (k >= 4 || data_out !== fill(exp_v[k % 4]) ||
                        !((r % 2 == 1) && (c % 2 == 1))) begin
                        bad++;
                        $display("FAIL mrst_out r=%0d c=%0d got=%0d exp=%0d", r, c,
                                 $signed(data_out[31:0]), exp_v[k % 4]);
                    end
                    k++;
                end
            end
        end
        total++;
        if (k !== 4) begin
            bad++;
            $display("FAIL mrst_count got=%0d exp=4", k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_signed();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
